// File: rtl/pong_renderer.sv
// ============================================================================
// pong_renderer
//   VGA raster generator with ball/paddle renderer. Free-running h/v counters
//   drive a one-stage output pipeline (rgb, sync, col, row, update_screen).
//   Object positions are shadowed once per frame so a frame never tears.
//   Timing geometry is parameterised; defaults give 640x480 @ 800x525.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_renderer #(
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_W  = 8,
  parameter int PADDLE_H  = 48,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] ball_top_i,
  input  logic [9:0] ball_left_i,
  input  logic [9:0] paddle_x_i,
  input  logic [9:0] paddle_y_i,
  output logic       update_screen_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [2:0] rgb_o,
  output logic [9:0] col_o,
  output logic [9:0] row_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam logic [10:0] BALL_EXT  = 11'(BALL_SIZE);
  localparam logic [10:0] PAD_W_EXT = 11'(PADDLE_W);
  localparam logic [10:0] PAD_H_EXT = 11'(PADDLE_H);

  // Raster counters
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  // Per-frame shadow copies of object positions
  logic [9:0] ball_top_q, ball_left_q, paddle_x_q, paddle_y_q;

  // Output pipeline registers
  logic [2:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [9:0] col_q, row_q;
  logic       update_q, update_d;

  // Hit-test intermediates (11-bit so right/bottom edges never wrap)
  logic        shadow_load;
  logic        visible;
  logic        ball_hit;
  logic        paddle_hit;
  logic [10:0] h_ext, v_ext;
  logic [10:0] ball_right, ball_bottom, pad_right, pad_bottom;

  // Next raster position: h wraps each line, v advances on the h wrap
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_MAX) begin
      h_d = 10'd0;
      v_d = (v_q == V_MAX) ? 10'd0 : v_q + 10'd1;
    end
  end

  // Raster counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= 10'd0;
      v_q <= 10'd0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign shadow_load = (h_q == H_MAX) && (v_q == V_MAX);

  // Capture object positions only on the last pixel of the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ball_top_q  <= 10'd0;
      ball_left_q <= 10'd0;
      paddle_x_q  <= 10'd0;
      paddle_y_q  <= 10'd0;
    end else if (shadow_load) begin
      ball_top_q  <= ball_top_i;
      ball_left_q <= ball_left_i;
      paddle_x_q  <= paddle_x_i;
      paddle_y_q  <= paddle_y_i;
    end
  end

  assign h_ext       = {1'b0, h_q};
  assign v_ext       = {1'b0, v_q};
  assign ball_right  = {1'b0, ball_left_q} + BALL_EXT;
  assign ball_bottom = {1'b0, ball_top_q}  + BALL_EXT;
  assign pad_right   = {1'b0, paddle_x_q}  + PAD_W_EXT;
  assign pad_bottom  = {1'b0, paddle_y_q}  + PAD_H_EXT;

  assign visible    = (h_q < H_VIS) && (v_q < V_VIS);
  assign ball_hit   = (h_q >= ball_left_q) && (h_ext < ball_right) &&
                      (v_q >= ball_top_q)  && (v_ext < ball_bottom);
  assign paddle_hit = (h_q >= paddle_x_q)  && (h_ext < pad_right) &&
                      (v_q >= paddle_y_q)  && (v_ext < pad_bottom);

  // Pixel colour, sync and frame-tick decode for the current raster position
  always_comb begin
    rgb_d = 3'b000;
    if (visible && ball_hit) begin
      rgb_d = 3'b111;
    end else if (visible && paddle_hit) begin
      rgb_d = 3'b010;
    end
    hsync_d  = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    vsync_d  = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    update_d = (h_q == 10'd0) && (v_q == V_VIS);
  end

  // One-cycle output pipeline keeping all outputs aligned with col/row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q    <= 3'b000;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      col_q    <= 10'd0;
      row_q    <= 10'd0;
      update_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      col_q    <= h_q;
      row_q    <= v_q;
      update_q <= update_d;
    end
  end

  assign rgb_o           = rgb_q;
  assign hsync_o         = hsync_q;
  assign vsync_o         = vsync_q;
  assign col_o           = col_q;
  assign row_o           = row_q;
  assign update_screen_o = update_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_renderer.sv
// ============================================================================
// tb_pong_renderer
//   Self-checking bench on a scaled-down raster (56x38 total, 40x30 visible).
//   The reference derives every pixel from the number of clocks since reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pong_renderer;

  localparam int HV = 40, HF = 4, HS = 8, HB = 4;
  localparam int VV = 30, VF = 3, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;  // 56
  localparam int VT = VV + VF + VS + VB;  // 38
  localparam int FT = HT * VT;            // 2128
  localparam int BS = 5, PW = 3, PH = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] ball_top = '0, ball_left = '0, paddle_x = '0, paddle_y = '0;
  logic       update_screen, hsync, vsync;
  logic [2:0] rgb;
  logic [9:0] col, row;

  pong_renderer #(
    .BALL_SIZE(BS), .PADDLE_W(PW), .PADDLE_H(PH),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ball_top_i(ball_top), .ball_left_i(ball_left),
    .paddle_x_i(paddle_x), .paddle_y_i(paddle_y),
    .update_screen_o(update_screen), .hsync_o(hsync), .vsync_o(vsync),
    .rgb_o(rgb), .col_o(col), .row_o(row)
  );

  initial forever #20 clk = ~clk;

  int compared = 0, mismatched = 0;

  // Reference state: clocks since reset and the positions latched for the frame
  int mcnt = 0;
  int s_bt = 0, s_bl = 0, s_px = 0, s_py = 0;
  // Observed statistics
  int edge_cnt = 0, wcnt = 0, gcnt = 0, hs_low = 0, vs_low = 0;
  int upd_n = 0, last_upd = 0, prev_upd = 0;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until the next pixel to be emitted sits at frame offset target
  task automatic align(input int target);
    int guard;
    guard = 0;
    while ((mcnt % FT) != target && guard < 3 * FT) begin
      @(negedge clk);
      guard++;
    end
    chk("align_timeout", (mcnt % FT) == target ? 1 : 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rgb"}, int'(rgb), 0);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_col"}, int'(col), 0);
    chk({tag, "_row"}, int'(row), 0);
    chk({tag, "_update"}, int'(update_screen), 0);
  endtask

  task automatic randomize_inputs();
    ball_top  = 10'($urandom_range(0, 40));
    ball_left = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(1018, 1023))
                                             : 10'($urandom_range(0, 60));
    paddle_x  = 10'($urandom_range(0, 60));
    paddle_y  = 10'($urandom_range(0, 40));
  endtask

  initial begin
    int w0, g0, h0, v0, u0;
    logic [25:0] act_v, exp_v;

    fork
      // Reference model and per-cycle compare
      forever begin
        int p, h, v;
        bit rs, vis, bh, ph;
        logic [2:0] e_rgb;
        logic e_hs, e_vs, e_up;
        logic [9:0] e_col, e_row;
        @(posedge clk);
        rs = rst_n;
        if (!rs) begin
          mcnt = 0; s_bt = 0; s_bl = 0; s_px = 0; s_py = 0;
          e_rgb = 3'd0; e_hs = 1'b1; e_vs = 1'b1; e_up = 1'b0;
          e_col = 10'd0; e_row = 10'd0;
        end else begin
          p = mcnt;
          mcnt++;
          h = p % HT;
          v = (p / HT) % VT;
          vis = (h < HV) && (v < VV);
          bh  = (h >= s_bl) && (h < s_bl + BS) && (v >= s_bt) && (v < s_bt + BS);
          ph  = (h >= s_px) && (h < s_px + PW) && (v >= s_py) && (v < s_py + PH);
          e_rgb = (vis && bh) ? 3'b111 : ((vis && ph) ? 3'b010 : 3'b000);
          e_hs  = !((h >= HV + HF) && (h < HV + HF + HS));
          e_vs  = !((v >= VV + VF) && (v < VV + VF + VS));
          e_up  = (h == 0) && (v == VV);
          e_col = 10'(h);
          e_row = 10'(v);
          if (h == HT - 1 && v == VT - 1) begin
            s_bt = int'(ball_top); s_bl = int'(ball_left);
            s_px = int'(paddle_x); s_py = int'(paddle_y);
          end
        end
        #1;
        act_v = {update_screen, hsync, vsync, rgb, col, row};
        exp_v = {e_up, e_hs, e_vs, e_rgb, e_col, e_row};
        compared++;
        if (act_v !== exp_v) begin
          mismatched++;
          $display("FAIL pixel t=%0t: got upd=%b hs=%b vs=%b rgb=%b col=%0d row=%0d expected upd=%b hs=%b vs=%b rgb=%b col=%0d row=%0d",
                   $time, update_screen, hsync, vsync, rgb, col, row,
                   e_up, e_hs, e_vs, e_rgb, e_col, e_row);
        end
        if (rs) begin
          edge_cnt++;
          if (rgb == 3'b111) wcnt++;
          if (rgb == 3'b010) gcnt++;
          if (!hsync) hs_low++;
          if (!vsync) vs_low++;
          if (update_screen) begin
            upd_n++;
            prev_upd = last_upd;
            last_upd = edge_cnt;
          end
        end else begin
          edge_cnt = 0;
        end
      end
    join_none

    // Reset state
    step(3);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    // Positions for frame 1, presented throughout frame 0
    ball_top = 10'd5; ball_left = 10'd10; paddle_x = 10'd30; paddle_y = 10'd0;

    // Frame 0 uses cleared shadows: ball and paddle overlap at the origin
    w0 = wcnt; g0 = gcnt; h0 = hs_low; v0 = vs_low; u0 = upd_n;
    step(FT);
    chk("f0_white", wcnt - w0, 25);
    chk("f0_green", gcnt - g0, 21);
    chk("f0_hsync_low", hs_low - h0, HS * VT);
    chk("f0_vsync_low", vs_low - v0, VS * HT);
    chk("f0_updates", upd_n - u0, 1);
    chk("first_update_edge", last_upd, VV * HT + 1);

    // Frame 1: inputs changed mid-frame must not affect it
    w0 = wcnt; g0 = gcnt; u0 = upd_n;
    step(1000);
    ball_top = 10'd27; ball_left = 10'd36; paddle_x = 10'd38; paddle_y = 10'd25;
    step(FT - 1000);
    chk("f1_white", wcnt - w0, 25);
    chk("f1_green", gcnt - g0, 36);
    chk("f1_updates", upd_n - u0, 1);
    chk("update_period", last_upd - prev_upd, FT);

    // Frame 2: clipped ball at bottom-right overlapping a clipped paddle
    w0 = wcnt; g0 = gcnt;
    step(FT);
    chk("f2_white", wcnt - w0, 12);
    chk("f2_green", gcnt - g0, 4);

    // Random positions, changed at arbitrary points in the frame
    for (int f = 0; f < 6 * FT; f++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) randomize_inputs();
    end

    // Reset mid visible area: outputs clear without waiting for a clock
    ball_top = 10'd12; ball_left = 10'd18; paddle_x = 10'd16; paddle_y = 10'd8;
    align(15 * HT + 20);
    step(FT);
    align(15 * HT + 20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    step(3);
    rst_n = 1'b1;
    u0 = upd_n;
    step(VV * HT + 10);
    chk("post_reset_updates", upd_n - u0, 1);
    chk("post_reset_update_edge", last_upd, VV * HT + 1);

    // Reset just before the frame tick: the aborted frame must not pulse
    align(VV * HT - 1);
    u0 = upd_n;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(VV * HT - 5);
    chk("aborted_frame_no_update", upd_n - u0, 0);
    step(10);
    chk("aborted_then_update", upd_n - u0, 1);
    chk("aborted_update_edge", last_upd, VV * HT + 1);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pong_renderer.md
PONG_RENDERER -- requirements
Module: pong_renderer

Interface
REQ-001 Parameter BALL_SIZE, default 8, meaning ball square side in pixels.
REQ-002 Parameter PADDLE_W, default 8, meaning paddle width in pixels.
REQ-003 Parameter PADDLE_H, default 48, meaning paddle height in pixels.
REQ-004 clock  input  1  pixel clock, 25 MHz; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; one clock domain only.
REQ-006 ball_top  input  10  ball top row from game state, screen pixels.
REQ-007 ball_left  input  10  ball left column from game state.
REQ-008 paddleX  input  10  paddle left column.
REQ-009 paddleY  input  10  paddle top row.
REQ-010 update_screen  output  1  one-cycle pulse at vblank start; game state advances one step per pulse.
REQ-011 hsync  output  1  VGA horizontal sync, active-low.
REQ-012 vsync  output  1  VGA vertical sync, active-low.
REQ-013 rgb  output  3  pixel colour {r,g,b}; 0 outside visible area.
REQ-014 col, row  output  10 each  registered coordinate of the pixel currently on rgb.

Function
REQ-015 Horizontal counter h SHALL count 0..799 and wrap to 0; vertical counter v SHALL increment when h wraps, count 0..524, wrap to 0.
REQ-016 Visible region SHALL be h<640 and v<480.
REQ-017 Raw hsync SHALL be low for h in 656..751 inclusive, else high.
REQ-018 Raw vsync SHALL be low for v in 490..491 inclusive, else high.
REQ-019 Shadow registers for ball_top, ball_left, paddleX, paddleY SHALL load only on the cycle h=799, v=524; inputs changing elsewhere SHALL not affect the frame in progress.
REQ-020 Ball hit SHALL be shadow_ball_left <= h < shadow_ball_left+BALL_SIZE and shadow_ball_top <= v < shadow_ball_top+BALL_SIZE.
REQ-021 Paddle hit SHALL use the same rule with PADDLE_W, PADDLE_H and paddleX/paddleY shadows.
REQ-022 Sums in REQ-020/021 SHALL be computed 11 bits wide; no wrap; objects past column 639 or row 479 SHALL clip.
REQ-023 Colour priority: visible and ball hit -> 3'b111; else visible and paddle hit -> 3'b010; else 3'b000.
REQ-024 rgb, hsync, vsync, col, row SHALL be registered with exactly 1 cycle latency from counter values; all five SHALL stay mutually aligned.
REQ-025 update_screen SHALL be high for exactly one cycle, the cycle after counters read h=0, v=480 (aligned with the REQ-024 pipeline); exactly one pulse per 420000-cycle frame.
REQ-026 Ball and paddle overlap SHALL render ball colour only.

Reset
REQ-027 While reset is low: h=0, v=0, shadows=0, rgb=0, col=0, row=0, hsync=1, vsync=1, update_screen=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; no update_screen pulse SHALL be produced by the aborted frame.
REQ-029 After reset deasserts, first rising edge SHALL begin at h=0, v=0; first update_screen SHALL occur 480*800+1 = 384001 cycles later.

Verification
REQ-030 Free-run two frames after reset -> hsync low 96 cycles per 800-cycle line; vsync low 1600 cycles per frame; update_screen pulses exactly twice, 420000 cycles apart.
REQ-031 ball_top=100, ball_left=200, paddle at (600,0) -> rgb=3'b111 only at row 100..107, col 200..207; 3'b010 only at col 600..607, row 0..47; 64 and 384 pixels respectively.
REQ-032 ball_left=636, ball_top=476 -> 4x4 clipped ball at col 636..639, row 476..479; no white in blank region or at col 0.
REQ-033 Change ball_left from 10 to 300 at v=200 -> current frame draws ball at col 10; next frame at col 300.
REQ-034 Ball (20,20) overlapping paddle (16,16) -> overlap pixels 3'b111; remaining paddle pixels 3'b010.
REQ-035 Assert reset at h=400, v=300 for 3 cycles -> outputs go to REQ-027 values asynchronously; next update_screen 384001 cycles after release.
